// File: rtl/store_pkg.sv
// Shared types for the buffered store controller: store kinds, drain FSM states
// and the queued-entry layout.
package store_pkg;

  // Queued word addresses are kept at this fixed width so AW can stay a module parameter.
  localparam int SQ_AW_MAX = 64;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } st_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sq_state_e;

  typedef struct packed {
    logic [SQ_AW_MAX-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           be;
  } sq_entry_t;

  function automatic logic [3:0] byte_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/st_lane_fmt.sv
// RV32 store lane formatter: replicates rs2 data across lanes, builds byte
// enables and flags misaligned or unknown store types.
module st_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  always_comb begin
    wdata    = '0;
    be       = '0;
    misalign = 1'b0;
    case (st_type)
      ST_SB: begin
        wdata = {4{data[7:0]}};
        be    = byte_be(addr_lo);
      end
      ST_SH: begin
        wdata    = {2{data[15:0]}};
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      ST_SW: begin
        wdata    = data;
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_queue_ctrl.sv
// Buffered store controller: formats and queues legal stores, drains them in
// order over mem_req/mem_gnt. Optional load-hazard compare: STORE_FWD_HAZARD_EN.
//
// state | meaning
// IDLE  | no request outstanding; launches when the queue holds an entry
// REQ   | head entry presented on mem_*, held until mem_gnt
module store_queue_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_gnt,
  input  logic          drain,
  output logic          empty,
  output logic          misalign_err,
  output logic [AW-1:0] err_addr,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sq_state_e     state;
  sq_entry_t     fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_nxt;
  logic          full_q;

  logic [31:0]   fmt_wdata;
  logic [3:0]    fmt_be;
  logic          fmt_misalign;
  logic          take, push, reject, pop;
  sq_entry_t     new_entry, head_entry, next_entry;

  st_lane_fmt u_fmt (
    .st_type  (st_type),
    .addr_lo  (st_addr[1:0]),
    .data     (st_data),
    .wdata    (fmt_wdata),
    .be       (fmt_be),
    .misalign (fmt_misalign)
  );

  // full_q comes from the registered count, so a pop this cycle cannot free a slot for a same-cycle push.
  assign st_ready = !full_q && !drain;
  assign empty    = (count == '0) && (state == IDLE);

  assign take   = st_valid && st_ready;
  assign push   = take && !fmt_misalign;
  assign reject = take && fmt_misalign;
  assign pop    = (state == REQ) && mem_gnt;

  assign new_entry.addr  = SQ_AW_MAX'(st_addr[AW-1:2]);
  assign new_entry.wdata = fmt_wdata;
  assign new_entry.be    = fmt_be;

  assign rd_ptr_next = rd_ptr + PW'(1);
  assign head_entry  = fifo_mem[rd_ptr];
  assign next_entry  = fifo_mem[rd_ptr_next];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full_q       <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_next;
      count        <= count_nxt;
      full_q       <= (count_nxt == DEPTH_C);
      misalign_err <= reject;
      if (reject) err_addr <= st_addr;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= {head_entry.addr[AW-3:0], 2'b00};
            mem_wdata <= head_entry.wdata;
            mem_be    <= head_entry.be;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            // Back-to-back drain: present the following entry with no idle cycle.
            if (count > CW'(1)) begin
              mem_addr  <= {next_entry.addr[AW-3:0], 2'b00};
              mem_wdata <= next_entry.wdata;
              mem_be    <= next_entry.be;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  logic unused_hi;
  assign unused_hi = ^{head_entry.addr[SQ_AW_MAX-1:AW-2], next_entry.addr[SQ_AW_MAX-1:AW-2]};

`ifdef STORE_FWD_HAZARD_EN
  logic [PW-1:0] slot_off [DEPTH];
  logic [DEPTH-1:0] slot_hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    assign slot_off[g] = PW'(g) - rd_ptr;
    assign slot_hit[g] = (CW'(slot_off[g]) < count)
                      && (fifo_mem[g].addr == SQ_AW_MAX'(ld_addr[AW-1:2]))
                      && (fifo_mem[g].be != 4'b0000);
  end

  assign ld_hazard = |slot_hit;

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];
`else
  assign ld_hazard = 1'b0;

  logic unused_ld;
  assign unused_ld = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed bench for store_queue_ctrl: expected writes and rejects go into
// queues at issue time; a negedge monitor pops them as the DUT presents them.
module tb_store_queue_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, st_ready;
  logic [1:0]    st_type;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          mem_req, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          drain, empty, misalign_err;
  logic [AW-1:0] err_addr, ld_addr;
  logic          ld_hazard;

  store_queue_ctrl #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt),
    .drain(drain), .empty(empty),
    .misalign_err(misalign_err), .err_addr(err_addr),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        wq[$];
  logic [31:0] eq[$];
  exp_t        mon_e;
  logic [31:0] mon_a;
  int          checks = 0;
  int          errors = 0;
  int          grant_cnt = 0;
  int          g0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.addr = a; e.wdata = d; e.be = b;
    wq.push_back(e);
  endtask

  // Scoreboard monitor: a write is committed on each edge where mem_req && mem_gnt.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      grant_cnt++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h expected no write", mem_addr);
      end else begin
        mon_e = wq.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("wr_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
        check("wr_be", 64'(mem_be), 64'(mon_e.be));
      end
    end
    if (!rst && misalign_err) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reject: got err_addr 0x%0h expected no pulse", err_addr);
      end else begin
        mon_a = eq.pop_front();
        check("err_addr", 64'(err_addr), 64'(mon_a));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_type = 2'b00; st_addr = '0; st_data = '0;
    mem_gnt = 1'b0; drain = 1'b0; ld_addr = '0;
    #2;
    check("rst_st_ready", 64'(st_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_misalign", 64'(misalign_err), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_ld_hazard", 64'(ld_hazard), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // SB to 0x103: lane 3, one cycle from accept to mem_req
    drive(2'b00, 32'h0000_0103, 32'hAABB_CCDD);
    exp_wr(32'h0000_0100, 32'hDDDD_DDDD, 4'b1000);
    tick();
    st_valid = 1'b0;
    check("lat_req_low", 64'(mem_req), 64'd0);
    tick();
    check("lat_req_high", 64'(mem_req), 64'd1);
    check("lat_addr", 64'(mem_addr), 64'h100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sb_empty", 64'(empty), 64'd1);

    // Back-to-back rejects: SH odd, type 11, SW misaligned
    drive(2'b01, 32'h0000_0201, 32'h1234_5678);
    eq.push_back(32'h0000_0201);
    tick();
    check("rej_pulse1", 64'(misalign_err), 64'd1);
    drive(2'b11, 32'h0000_0000, 32'h0);
    eq.push_back(32'h0000_0000);
    tick();
    drive(2'b10, 32'h0000_0006, 32'h0);
    eq.push_back(32'h0000_0006);
    tick();
    st_valid = 1'b0;
    tick();
    check("rej_end", 64'(misalign_err), 64'd0);
    check("rej_err_hold", 64'(err_addr), 64'h6);
    check("rej_no_req", 64'(mem_req), 64'd0);
    check("rej_empty", 64'(empty), 64'd1);

    // SH upper half and SB lane 1 with grant always available
    mem_gnt = 1'b1;
    drive(2'b01, 32'h0000_0202, 32'h1234_5678);
    exp_wr(32'h0000_0200, 32'h5678_5678, 4'b1100);
    tick();
    drive(2'b00, 32'h0000_0001, 32'h0000_00EE);
    exp_wr(32'h0000_0000, 32'hEEEE_EEEE, 4'b0010);
    tick();
    st_valid = 1'b0;
    repeat (4) tick();
    mem_gnt = 1'b0;
    check("mix_empty", 64'(empty), 64'd1);

    // Fill four SWs with no grant, then burst-drain
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'(4 * i), 32'h1111_1111 * (i + 1));
      exp_wr(32'(4 * i), 32'h1111_1111 * (i + 1), 4'b1111);
      tick();
    end
    st_valid = 1'b0;
    check("full_ready", 64'(st_ready), 64'd0);
    repeat (3) tick();
    check("hold_req", 64'(mem_req), 64'd1);
    check("hold_addr", 64'(mem_addr), 64'h0);
    check("hold_wdata", 64'(mem_wdata), 64'h1111_1111);
    g0 = grant_cnt;
    mem_gnt = 1'b1;
    repeat (4) tick();
    mem_gnt = 1'b0;
    check("burst_grants", 64'(grant_cnt - g0), 64'd4);
    check("burst_empty", 64'(empty), 64'd1);
    check("burst_sb_left", 64'(wq.size()), 64'd0);

    // Full queue: push in the same cycle as a grant is refused
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      exp_wr(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
      tick();
    end
    check("refill_full", 64'(st_ready), 64'd0);
    drive(2'b10, 32'h0000_0020, 32'hB000_0020);
    exp_wr(32'h0000_0020, 32'hB000_0020, 4'b1111);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("pop_frees", 64'(st_ready), 64'd1);
    tick();
    st_valid = 1'b0;
    check("late_push_full", 64'(st_ready), 64'd0);
    mem_gnt = 1'b1;
    repeat (4) tick();
    mem_gnt = 1'b0;
    check("refill_empty", 64'(empty), 64'd1);

    // Fence: drain holds st_ready low until released
    drive(2'b10, 32'h0000_0030, 32'hC0DE_0030);
    exp_wr(32'h0000_0030, 32'hC0DE_0030, 4'b1111);
    tick();
    st_valid = 1'b0;
    drain = 1'b1;
    #1;
    check("drain_ready", 64'(st_ready), 64'd0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_hold", 64'(st_ready), 64'd0);
    drain = 1'b0;
    #1;
    check("drain_release", 64'(st_ready), 64'd1);

    // Load hazard against a pending SW at 0x40
    ld_addr = 32'h0000_0042;
    drive(2'b10, 32'h0000_0040, 32'hCAFE_0040);
    exp_wr(32'h0000_0040, 32'hCAFE_0040, 4'b1111);
    tick();
    st_valid = 1'b0;
`ifdef STORE_FWD_HAZARD_EN
    check("hz_queued", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h0000_0044;
    #1;
    check("hz_other_word", 64'(ld_hazard), 64'd0);
    ld_addr = 32'h0000_0042;
    tick();
    check("hz_in_req", 64'(ld_hazard), 64'd1);
    mem_gnt = 1'b1;
    #1;
    check("hz_granting", 64'(ld_hazard), 64'd1);
    tick();
    mem_gnt = 1'b0;
    check("hz_popped", 64'(ld_hazard), 64'd0);
`else
    check("hz_off_queued", 64'(ld_hazard), 64'd0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("hz_off_popped", 64'(ld_hazard), 64'd0);
`endif

    // Async reset mid-REQ with two entries: both are lost
    drive(2'b10, 32'h0000_0050, 32'h5050_5050);
    tick();
    drive(2'b10, 32'h0000_0054, 32'h5454_5454);
    tick();
    st_valid = 1'b0;
    check("pre_rst_req", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", 64'(mem_req), 64'd0);
    check("async_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_ready", 64'(st_ready), 64'd1);
    repeat (3) tick();
    check("post_rst_req", 64'(mem_req), 64'd0);
    check("post_rst_empty", 64'(empty), 64'd1);

    repeat (2) tick();
    check("wr_left", 64'(wq.size()), 64'd0);
    check("rej_left", 64'(eq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
